// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin arbiter sharing one bitwise logic unit
// (AND/OR/XOR/XNOR) between NREQ requesters.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_req_valid/o_req_ready  per-requester handshake (ready only in IDLE)
//   i_req_op/i_req_a/i_req_b packed per-requester op and operands
//   o_rsp_valid/i_rsp_ready  response handshake
//   o_rsp_result/o_rsp_id    result and originating requester index
//   o_busy              high whenever the FSM is not in IDLE
module logic_unit_arbiter #(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req_valid,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic [2*NREQ-1:0]       i_req_op,
  input  logic [WIDTH*NREQ-1:0]   i_req_a,
  input  logic [WIDTH*NREQ-1:0]   i_req_b,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [WIDTH-1:0]        o_rsp_result,
  output logic [IDW-1:0]          o_rsp_id,
  output logic                    o_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDW-1:0]   r_id;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic [IDW-1:0]   r_rsp_id;

  logic [1:0]       w_op_arr [NREQ];
  logic [WIDTH-1:0] w_a_arr  [NREQ];
  logic [WIDTH-1:0] w_b_arr  [NREQ];
  logic             w_found;
  logic [IDW-1:0]   w_gnt;
  logic [IDW-1:0]   w_cand;
  logic [IDW-1:0]   w_ptr_nxt;

  // Unpack per-requester payload slices
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_op_arr[g] = i_req_op[2*g +: 2];
    assign w_a_arr[g]  = i_req_a[WIDTH*g +: WIDTH];
    assign w_b_arr[g]  = i_req_b[WIDTH*g +: WIDTH];
  end

  // Round-robin search: first valid requester at or after r_ptr, wrapping
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = IDW'((32'(r_ptr) + k) % NREQ);
      if (!w_found && i_req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end
    end
  end

  assign w_ptr_nxt = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + IDW'(1);

  // Grant is combinational, only offered in IDLE and never during reset
  assign o_req_ready = (i_rst_n && (r_state == ST_IDLE) && w_found)
                       ? (NREQ'(1) << w_gnt) : '0;

  function automatic logic [WIDTH-1:0] f_logic(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   f_logic = a & b;
      2'b01:   f_logic = a | b;
      2'b10:   f_logic = a ^ b;
      default: f_logic = ~(a ^ b);
    endcase
  endfunction

  // Control FSM with capture, execute and response registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_id     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_op    <= w_op_arr[w_gnt];
            r_a     <= w_a_arr[w_gnt];
            r_b     <= w_b_arr[w_gnt];
            r_id    <= w_gnt;
            r_ptr   <= w_ptr_nxt;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_result <= f_logic(r_op, r_a, r_b);
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_id     = r_rsp_id;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed testbench for logic_unit_arbiter (WIDTH=4, NREQ=4).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_result;
  logic [1:0]  rsp_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(4), .NREQ(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_id(rsp_id), .o_busy(busy)
  );

  task automatic set_req(input int i, input logic [1:0] op,
                         input logic [3:0] a, input logic [3:0] b);
    req_op[2*i +: 2] = op;
    req_a[4*i +: 4]  = a;
    req_b[4*i +: 4]  = b;
    req_valid[i]     = 1'b1;
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rsp_ready = 1'b0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    step(); step();
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_result !== 4'b0000) begin errors++; $display("FAIL reset_result got=%b exp=0000", rsp_result); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    req_valid = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // One isolated transaction from requester i, consumed as soon as valid
  task automatic test_single_op(input string nm, input int i, input logic [1:0] op,
                                input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] exp_res);
    logic [3:0] exp_rdy;
    exp_rdy = 4'b0001 << i;
    set_req(i, op, a, b);
    #1;
    checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL %s_grant got=%b exp=%b", nm, req_ready, exp_rdy); end
    step();
    req_valid = '0;
    #1;
    checks++; if ({busy, rsp_valid, req_ready} !== 6'b100000) begin errors++; $display("FAIL %s_exec got busy/valid/ready=%b exp=100000", nm, {busy, rsp_valid, req_ready}); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL %s_rsp_valid got=%b exp=1", nm, rsp_valid); end
    checks++; if (rsp_result !== exp_res) begin errors++; $display("FAIL %s_result got=%b exp=%b", nm, rsp_result, exp_res); end
    checks++; if (rsp_id !== 2'(i)) begin errors++; $display("FAIL %s_id got=%0d exp=%0d", nm, rsp_id, i); end
    rsp_ready = 1'b1;
    step();
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL %s_done got valid/busy=%b exp=00", nm, {rsp_valid, busy}); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_basic;
    test_single_op("xnor_eq", 0, 2'b11, 4'b1010, 4'b1010, 4'b1111);
  endtask

  task automatic test_ops;
    test_single_op("xnor2", 2, 2'b11, 4'b0111, 4'b1001, 4'b0001);
    test_single_op("and2",  2, 2'b00, 4'b0111, 4'b1001, 4'b0001);
    test_single_op("or2",   2, 2'b01, 4'b0111, 4'b1001, 4'b1111);
    test_single_op("xor2",  2, 2'b10, 4'b0111, 4'b1001, 4'b1110);
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_res [4];
    int order [5];
    exp_res = '{4'b1000, 4'b1110, 4'b0110, 4'b1001};
    order   = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 4'b1100, 4'b1010);
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (req_ready !== (4'b0001 << order[k])) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, 4'b0001 << order[k]); end
      step();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_exec_ready%0d got=%b exp=0000", k, req_ready); end
      step();
      checks++; if ({rsp_valid, rsp_id} !== {1'b1, 2'(order[k])}) begin errors++; $display("FAIL rr_rsp%0d got valid/id=%b/%0d exp=1/%0d", k, rsp_valid, rsp_id, order[k]); end
      checks++; if (rsp_result !== exp_res[order[k]]) begin errors++; $display("FAIL rr_result%0d got=%b exp=%b", k, rsp_result, exp_res[order[k]]); end
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_backpressure;
    // ptr is 1 here; req3 alone wins, later req1 wins from ptr 0
    set_req(3, 2'b01, 4'b0101, 4'b0010);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant got=%b exp=1000", req_ready); end
    step();
    req_valid = '0;
    step();
    set_req(1, 2'b10, 4'b1111, 4'b0101);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({rsp_valid, busy, req_ready, rsp_id, rsp_result} !== {1'b1, 1'b1, 4'b0000, 2'd3, 4'b0111})
        begin errors++; $display("FAIL bp_hold%0d got valid/busy/ready/id/res=%b/%b/%b/%0d/%b exp=1/1/0000/3/0111", c, rsp_valid, busy, req_ready, rsp_id, rsp_result); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_release got valid/busy=%b exp=00", {rsp_valid, busy}); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_next_grant got=%b exp=0010", req_ready); end
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    step();
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd1, 4'b1010}) begin errors++; $display("FAIL bp_next_rsp got valid/id/res=%b/%0d/%b exp=1/1/1010", rsp_valid, rsp_id, rsp_result); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_operand_change;
    set_req(2, 2'b00, 4'b1111, 4'b0110);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL opchg_grant got=%b exp=0100", req_ready); end
    step();
    req_valid = '0;
    req_a[11:8] = 4'b0000;
    req_b[11:8] = 4'b0000;
    step();
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd2, 4'b0110}) begin errors++; $display("FAIL opchg_rsp got valid/id/res=%b/%0d/%b exp=1/2/0110", rsp_valid, rsp_id, rsp_result); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    // ptr is 3; granting req2 moves it to 3, reset must bring it back to 0
    set_req(2, 2'b10, 4'b0001, 4'b0011);
    step();
    req_valid = '0;
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_resp got=%b exp=1", rsp_valid); end
    set_req(1, 2'b01, 4'b1000, 4'b0001);
    set_req(3, 2'b00, 4'b1110, 4'b0111);
    rst_n = 1'b0;
    step();
    checks++; if ({rsp_valid, busy, req_ready} !== 6'b000000) begin errors++; $display("FAIL rmid_reset got valid/busy/ready=%b exp=000000", {rsp_valid, busy, req_ready}); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_grant1 got=%b exp=0010", req_ready); end
    step();
    req_valid[1] = 1'b0;
    step();
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd1, 4'b1001}) begin errors++; $display("FAIL rmid_rsp1 got valid/id/res=%b/%0d/%b exp=1/1/1001", rsp_valid, rsp_id, rsp_result); end
    rsp_ready = 1'b1;
    step();
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rmid_grant3 got=%b exp=1000", req_ready); end
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    step();
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd3, 4'b0110}) begin errors++; $display("FAIL rmid_rsp3 got valid/id/res=%b/%0d/%b exp=1/3/0110", rsp_valid, rsp_id, rsp_result); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ops();
    test_round_robin();
    test_backpressure();
    test_operand_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one bitwise logic unit (AND/OR/XOR/XNOR on WIDTH-bit operands) between NREQ requesters. Round-robin arbitration selects one pending request, the block captures its operands, computes the result in a registered execute stage, and returns it with the requester's ID over a valid/ready response channel. It sits between the per-client request ports and the shared binary-logic datapath in the BinaryLogic step of the design.

## Interface
- WIDTH, 4, operand/result width in bits
- NREQ, 4, number of requesters; ID width IDW = $clog2(NREQ), minimum 1
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
- req_op  input  2*NREQ  packed op per requester, bits [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 XNOR
- req_a  input  WIDTH*NREQ  packed operand A, slice [WIDTH*i +: WIDTH]
- req_b  input  WIDTH*NREQ  packed operand B, same packing
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  WIDTH  result of the granted operation
- rsp_id  output  IDW  index of requester that issued the operation
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid bit is high, grant winner g = first set bit searching from ptr upward, wrapping mod NREQ. req_ready[g] = 1 combinationally in the same cycle (only in IDLE). On that edge: capture op_r, a_r, b_r, id_r = g; ptr <= (g+1) mod NREQ; go EXEC. No valid -> stay IDLE, ptr unchanged.
- EXEC: rsp_result <= f(op_r, a_r, b_r); rsp_id <= id_r; rsp_valid <= 1; go RESP. XNOR = ~(a ^ b), full WIDTH, no carries.
- RESP: hold rsp_valid, rsp_result, rsp_id stable while rsp_ready = 0. On the edge with rsp_ready = 1: rsp_valid <= 0, go IDLE.
- req_ready is all zero in EXEC and RESP; new requests wait (requesters hold valid and payload until ready).
- Requester dropping req_valid before grant: not granted, no state change.
- Operands are sampled only at the grant edge; later changes on req_a/req_b do not affect the in-flight result.

## Timing
- Reset (rst_n = 0 at a rising edge): state = IDLE, ptr = 0, rsp_valid = 0, rsp_result = 0, rsp_id = 0, busy = 0, req_ready = 0 while rst_n low. Applies mid-operation: an in-flight EXEC/RESP transaction is discarded, no response emitted.
- Grant edge at cycle N (IDLE, req_ready[g] = 1) -> rsp_valid = 1 from cycle N+2.
- Response consumed at edge M (rsp_valid & rsp_ready) -> back in IDLE at M+1; next grant possible at cycle M+1.
- Minimum issue interval 3 cycles with rsp_ready tied high.
- busy = 1 from cycle N+1 through the cycle of response handshake.
- Simultaneous requests: exactly one granted per IDLE cycle; with all NREQ continuously valid, grant order is ptr, ptr+1, ... wrapping; no requester waits more than NREQ grants.
- ptr wrap: grant of NREQ-1 sets ptr = 0.

## Test plan
- Reset then req0: op=11, a=1010, b=1010 -> req_ready[0] in grant cycle, rsp_valid 2 cycles later, rsp_result=1111, rsp_id=0.
- req2: op=11, a=0111, b=1001 -> rsp_result=0001, rsp_id=2; repeat with op 00/01/10 -> 0001, 1111, 1110.
- All four requesting continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_id matches; one req_ready bit per grant, grants 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_result, rsp_id stable, req_ready=0, busy=1; release -> rsp_valid low next cycle, next grant follows.
- Operand change after grant: req_a altered in EXEC -> result reflects captured values.
- rst_n pulled low for one cycle during RESP -> rsp_valid=0, busy=0, ptr=0 next cycle; pending req1 and req3 then granted in order 1, 3.
